reg_writeback: RTL and testbench



---
 rtl/reg_wb_pkg.sv | 31 +++
 rtl/reg_writeback_if.sv | 42 ++++
 rtl/reg_writeback_rr_arbiter.sv | 31 +++
 rtl/reg_writeback.sv | 108 ++++++++++
 tb/tb_reg_writeback.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package reg_wb_pkg;

   localparam int REG_DATA_WIDTH_POW = 6;
   localparam int REG_DATA_WIDTH     = 1 << REG_DATA_WIDTH_POW;
   localparam int REG_MEM_DEPTH_POW  = 5;
   localparam int MAX_SRC            = 8;
   localparam int SRC_IDX_W          = $clog2(MAX_SRC);

   typedef logic [REG_MEM_DEPTH_POW-1:0] reg_idx_t;
   typedef logic [REG_DATA_WIDTH-1:0]    reg_data_t;
   typedef logic [SRC_IDX_W-1:0]         src_idx_t;

   typedef struct packed {
      logic      valid;
      reg_idx_t  rd;
      reg_data_t data;
   } wb_entry_t;

   // Round-robin successor: the producer after idx becomes highest priority.
   function automatic src_idx_t rr_next(input src_idx_t idx, input int n);
      src_idx_t nxt;
      if (int'(idx) + 1 >= n) begin
         nxt = '0;
      end else begin
         nxt = idx + src_idx_t'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Producer handshakes, register-file write port and (with REG_WB_BYPASS_EN) bypass query port.
interface reg_writeback_if #(
   parameter int NUM_SRC = 3
);
   import reg_wb_pkg::*;

   logic [NUM_SRC-1:0]                        src_valid_in;
   logic [NUM_SRC-1:0]                        src_ready_out;
   logic [NUM_SRC-1:0][REG_MEM_DEPTH_POW-1:0] src_rd_in;
   logic [NUM_SRC-1:0][REG_DATA_WIDTH-1:0]    src_data_in;

   logic [REG_MEM_DEPTH_POW-1:0]              rd_out;
   logic [REG_DATA_WIDTH-1:0]                 data_write_out;
   logic                                      write_en_out;

`ifdef REG_WB_BYPASS_EN
   logic [1:0][REG_MEM_DEPTH_POW-1:0]         qry_rs_in;
   logic [1:0]                                qry_hit_out;
   logic [1:0][REG_DATA_WIDTH-1:0]            qry_data_out;

   modport master (
      output src_valid_in, src_rd_in, src_data_in, qry_rs_in,
      input  src_ready_out, rd_out, data_write_out, write_en_out, qry_hit_out, qry_data_out
   );

   modport slave (
      input  src_valid_in, src_rd_in, src_data_in, qry_rs_in,
      output src_ready_out, rd_out, data_write_out, write_en_out, qry_hit_out, qry_data_out
   );
`else
   modport master (
      output src_valid_in, src_rd_in, src_data_in,
      input  src_ready_out, rd_out, data_write_out, write_en_out
   );

   modport slave (
      input  src_valid_in, src_rd_in, src_data_in,
      output src_ready_out, rd_out, data_write_out, write_en_out
   );
`endif

endinterface

// File: rtl/reg_writeback_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (mod N) wins.
module rr_arbiter
   import reg_wb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   input  src_idx_t     ptr,
   output logic [N-1:0] grant,
   output src_idx_t     idx
);

   int   cand;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = src_idx_t'(cand);
         end
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter: one-entry buffer per producer, round-robin grant, registered write port.
// Optional bypass query port enabled by defining REG_WB_BYPASS_EN.
module reg_writeback
   import reg_wb_pkg::*;
#(
   parameter int NUM_SRC = 3
) (
   input  logic            clk_in,
   input  logic            reset,
   reg_writeback_if.slave  wb
);

   logic [NUM_SRC-1:0] buf_vld;
   reg_idx_t           buf_rd   [NUM_SRC];
   reg_data_t          buf_data [NUM_SRC];

   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] accept;
   logic               gnt_any;
   src_idx_t           gnt_idx;
   src_idx_t           rr_ptr;

   wb_entry_t          sel_p0;
   wb_entry_t          out_p1;

   // A buffer being drained this cycle can take a new result at the same edge.
   assign wb.src_ready_out = {NUM_SRC{!reset}} & (~buf_vld | grant);
   assign accept           = wb.src_valid_in & wb.src_ready_out;
   assign gnt_any          = |grant;

   rr_arbiter #(.N(NUM_SRC)) u_arb (
      .req   (buf_vld),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gnt_idx)
   );

   // ---- stage p0: producer buffers ----
   // Results for x0 are accepted but never marked valid, so they are absorbed here.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         buf_vld <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
               buf_vld[i] <= (wb.src_rd_in[i] != '0);
            end else if (grant[i]) begin
               buf_vld[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (accept[i]) begin
            buf_rd[i]   <= wb.src_rd_in[i];
            buf_data[i] <= wb.src_data_in[i];
         end
      end
   end

   // Grant is one-hot, so an AND-OR mux selects the winning entry.
   always_comb begin
      sel_p0       = '0;
      sel_p0.valid = gnt_any;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            sel_p0.rd   = sel_p0.rd   | buf_rd[i];
            sel_p0.data = sel_p0.data | buf_data[i];
         end
      end
   end

   // ---- stage p1: registered register-file write port ----
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         out_p1 <= '0;
         rr_ptr <= '0;
      end else begin
         out_p1.valid <= sel_p0.valid;
         if (gnt_any) begin
            out_p1.rd   <= sel_p0.rd;
            out_p1.data <= sel_p0.data;
            rr_ptr      <= rr_next(gnt_idx, NUM_SRC);
         end
      end
   end

   assign wb.write_en_out   = out_p1.valid;
   assign wb.rd_out         = out_p1.rd;
   assign wb.data_write_out = out_p1.data;

`ifdef REG_WB_BYPASS_EN
   // Forwards the in-flight write during the cycle before the register file holds it.
   always_comb begin
      wb.qry_hit_out  = '0;
      wb.qry_data_out = '0;
      for (int j = 0; j < 2; j++) begin
         if (out_p1.valid && (out_p1.rd == wb.qry_rs_in[j]) && (wb.qry_rs_in[j] != '0)) begin
            wb.qry_hit_out[j]  = 1'b1;
            wb.qry_data_out[j] = out_p1.data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: single write, x0 drop, round-robin, backpressure, reset, bypass.
module tb_reg_writeback;
   import reg_wb_pkg::*;

   localparam int NS = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   reg_writeback_if #(.NUM_SRC(NS)) wb ();

   reg_writeback #(.NUM_SRC(NS)) dut (
      .clk_in (clk),
      .reset  (rst),
      .wb     (wb.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      wb.src_valid_in = '0;
      wb.src_rd_in    = '0;
      wb.src_data_in  = '0;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   int   lst [3][4];
   int   cnt [3];
   int   pos [3];
   int   exp_wr [8];
   logic [NS-1:0] rdy;

   initial begin
      clear_inputs();
`ifdef REG_WB_BYPASS_EN
      wb.qry_rs_in = '0;
`endif
      // Reset state
      #1;
      chk("rst_we",    64'(wb.write_en_out),   64'd0);
      chk("rst_rd",    64'(wb.rd_out),         64'd0);
      chk("rst_data",  64'(wb.data_write_out), 64'd0);
      chk("rst_ready", 64'(wb.src_ready_out),  64'd0);
      #11 rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(wb.src_ready_out), 64'd7);

      // Single write: accept at edge k, write strobe after edge k+1 for one cycle
      tick();
      wb.src_valid_in   = 3'b001;
      wb.src_rd_in[0]   = 5'd5;
      wb.src_data_in[0] = 64'hDEAD_BEEF;
      tick();
      clear_inputs();
      chk("single_we_k", 64'(wb.write_en_out), 64'd0);
      tick();
      chk("single_we_k1",   64'(wb.write_en_out),   64'd1);
      chk("single_rd_k1",   64'(wb.rd_out),         64'd5);
      chk("single_data_k1", 64'(wb.data_write_out), 64'hDEAD_BEEF);
      tick();
      chk("single_we_k2", 64'(wb.write_en_out), 64'd0);

      // x0 result is accepted and absorbed
      wb.src_valid_in   = 3'b010;
      wb.src_rd_in[1]   = 5'd0;
      wb.src_data_in[1] = 64'h1234;
      chk("x0_ready", 64'(wb.src_ready_out[1]), 64'd1);
      tick();
      clear_inputs();
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("x0_we_%0d", c), 64'(wb.write_en_out), 64'd0);
      end
      chk("x0_ready_after", 64'(wb.src_ready_out), 64'd7);

      // Round-robin from rr_ptr = 0, twice
      pulse_reset();
      for (int r = 0; r < 2; r++) begin
         tick();
         wb.src_valid_in = 3'b111;
         for (int i = 0; i < NS; i++) begin
            wb.src_rd_in[i]   = 5'(i + 1);
            wb.src_data_in[i] = 64'hA0 + 64'(16 * r + i + 1);
         end
         tick();
         clear_inputs();
         for (int i = 0; i < NS; i++) begin
            tick();
            chk($sformatf("rr%0d_we_%0d", r, i),   64'(wb.write_en_out),   64'd1);
            chk($sformatf("rr%0d_rd_%0d", r, i),   64'(wb.rd_out),         64'(i + 1));
            chk($sformatf("rr%0d_data_%0d", r, i), 64'(wb.data_write_out), 64'hA0 + 64'(16 * r + i + 1));
         end
      end
      tick();
      chk("rr_idle_we", 64'(wb.write_en_out), 64'd0);

      // Backpressure: src0 streams 7..10, src1 sends 11,12, src2 sends 13,14
      lst = '{'{7, 8, 9, 10}, '{11, 12, 0, 0}, '{13, 14, 0, 0}};
      cnt = '{4, 2, 2};
      pos = '{0, 0, 0};
      exp_wr = '{7, 11, 13, 8, 12, 14, 9, 10};
      for (int cyc = 1; cyc <= 10; cyc++) begin
         for (int i = 0; i < NS; i++) begin
            wb.src_valid_in[i] = (pos[i] < cnt[i]);
            wb.src_rd_in[i]    = (pos[i] < cnt[i]) ? 5'(lst[i][pos[i]]) : 5'd0;
            wb.src_data_in[i]  = (pos[i] < cnt[i]) ? 64'h100 + 64'(lst[i][pos[i]]) : 64'd0;
         end
         rdy = wb.src_ready_out;
         tick();
         for (int i = 0; i < NS; i++) begin
            if (wb.src_valid_in[i] && rdy[i]) pos[i]++;
         end
         if (cyc == 2) chk("bp_ready_e2", 64'(wb.src_ready_out), 64'd2);
         if (cyc == 3) chk("bp_ready_e3", 64'(wb.src_ready_out), 64'd4);
         if (cyc >= 2 && cyc <= 9) begin
            chk($sformatf("bp_we_%0d", cyc),   64'(wb.write_en_out),   64'd1);
            chk($sformatf("bp_rd_%0d", cyc),   64'(wb.rd_out),         64'(exp_wr[cyc-2]));
            chk($sformatf("bp_data_%0d", cyc), 64'(wb.data_write_out), 64'h100 + 64'(exp_wr[cyc-2]));
         end
         if (cyc == 10) chk("bp_we_idle", 64'(wb.write_en_out), 64'd0);
      end
      clear_inputs();

      // Reset mid-flight: buffers full, one write in flight
      wb.src_valid_in = 3'b111;
      for (int i = 0; i < NS; i++) begin
         wb.src_rd_in[i]   = 5'(20 + i);
         wb.src_data_in[i] = 64'hC0 + 64'(i);
      end
      tick();
      clear_inputs();
      tick();
      chk("mid_we_before", 64'(wb.write_en_out), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_we_rst",    64'(wb.write_en_out),  64'd0);
      chk("mid_ready_rst", 64'(wb.src_ready_out), 64'd0);
      chk("mid_rd_rst",    64'(wb.rd_out),        64'd0);
      #1 rst = 1'b0;
      #1;
      chk("mid_ready_rel", 64'(wb.src_ready_out), 64'd7);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("mid_stale_we_%0d", c), 64'(wb.write_en_out), 64'd0);
      end

`ifdef REG_WB_BYPASS_EN
      // Bypass hit during the write strobe cycle only
      wb.src_valid_in   = 3'b001;
      wb.src_rd_in[0]   = 5'd9;
      wb.src_data_in[0] = 64'h55;
      wb.qry_rs_in[0]   = 5'd9;
      wb.qry_rs_in[1]   = 5'd0;
      tick();
      clear_inputs();
      chk("byp_hit_k", 64'(wb.qry_hit_out), 64'd0);
      tick();
      chk("byp_hit_k1",   64'(wb.qry_hit_out),     64'd1);
      chk("byp_data0_k1", 64'(wb.qry_data_out[0]), 64'h55);
      chk("byp_data1_k1", 64'(wb.qry_data_out[1]), 64'd0);
      tick();
      chk("byp_hit_k2", 64'(wb.qry_hit_out), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
